// File: rtl/inst_axi_rd_bridge.sv
// Purpose: bridges the fetch stage's req/addr_ok/data_ok read port onto AXI4 AR/R, single-beat in-order reads.
// Latency: accept -> arvalid 1 cycle; R beat -> data_ok/rdata combinational in the handshake cycle.
// Backpressure: arready low holds the AR beat stable and blocks new accepts; accepts stop at MAX_OUTSTANDING in flight.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID_VAL        = 4'd0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch-side SRAM-like port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  axi_arid,
  // AXI read-address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read-data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  ar_state_e        state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [2:0]       arsize_q, arsize_d;
  logic             arvalid_q, arvalid_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic r_done;
  logic cnt_room;
  logic accept;

  // The response status is deliberately not forwarded; fetch only sees data.
  logic unused_rresp;
  assign unused_rresp = ^rresp;

  // Fixed AR attributes: single-beat INCR, normal access, ARID_VAL on every read.
  assign arid     = ARID_VAL;
  assign axi_arid = ARID_VAL;
  assign arlen    = 8'd0;
  assign arburst  = 2'b01;
  assign arlock   = 2'b00;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;

  // R side: only a final beat carrying our ID retires a read; foreign IDs are
  // left unacknowledged to fetch and do not touch the outstanding count.
  assign rready            = (out_cnt_q != '0);
  assign r_done            = rvalid & rready & rlast & (rid == ARID_VAL);
  assign inst_sram_data_ok = r_done;
  assign inst_sram_rdata   = rdata;

  // A read retiring this cycle frees its slot immediately, so a full bridge can
  // accept in the same cycle as a return; the counter then holds its value.
  // Gating with resetn keeps addr_ok low while reset is asserted even if fetch
  // keeps req high.
  assign cnt_room          = (out_cnt_q < CNT_MAX) | r_done;
  assign accept            = resetn & (state_q == AR_IDLE) & inst_sram_req &
                             ~inst_sram_wr & cnt_room;
  assign inst_sram_addr_ok = accept;

  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;

  // AR FSM next state: latch the request on accept, hold it until arready.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arvalid_d = arvalid_q;
    case (state_q)
      AR_IDLE: begin
        if (accept) begin
          araddr_d  = inst_sram_addr;
          arsize_d  = {1'b0, inst_sram_size};
          arvalid_d = 1'b1;
          state_d   = AR_SEND;
        end
      end
      AR_SEND: begin
        if (arvalid_q & arready) begin
          arvalid_d = 1'b0;
          state_d   = AR_IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = AR_IDLE;
      end
    endcase
  end

  // Outstanding count: +1 per accept, -1 per retired read, unchanged when both.
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({accept, r_done})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State, AR payload and counter registers; reset drops all pending reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= AR_IDLE;
      araddr_q  <= 32'd0;
      arsize_q  <= 3'd0;
      arvalid_q <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arvalid_q <= arvalid_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: the bench plays fetch and the AXI slave.
// Expected read data is queued when a request is accepted and compared on data_ok.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  axi_arid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.ARID_VAL(4'd0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .axi_arid(axi_arid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  // Slave memory contents as a function of address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_chk(input logic v, input logic [31:0] a);
    chk("arvalid", {31'd0, arvalid}, {31'd0, v});
    if (v) begin
      chk("araddr", araddr, a);
      chk("arsize", {29'd0, arsize}, 32'd2);
    end
  endtask

  task automatic aok_chk(input logic v);
    chk("addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, v});
  endtask

  task automatic rdy_chk(input logic v);
    chk("rready", {31'd0, rready}, {31'd0, v});
  endtask

  // data_ok check plus scoreboard pop of the oldest expected read.
  task automatic sample_r(input logic exp_dok);
    logic [31:0] e;
    chk("data_ok", {31'd0, inst_sram_data_ok}, {31'd0, exp_dok});
    if (inst_sram_data_ok === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=data_ok expected=no_pending_read");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", inst_sram_rdata, e);
      end
    end
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rid    = id;
    rdata  = d;
  endtask

  task automatic no_beat();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = 4'd0;
    rdata  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_addr = 32'h1C00_0000;
    arready = 1'b0; rresp = 2'b00;
    no_beat();

    // ---- reset state (req held high to show addr_ok stays low) ----
    repeat (2) adv();
    @(negedge clk);
    aok_chk(1'b0); ar_chk(1'b0, 32'd0); rdy_chk(1'b0); sample_r(1'b0);
    chk("araddr_rst", araddr, 32'd0);
    chk("arsize_rst", {29'd0, arsize}, 32'd0);
    chk("arid", {28'd0, arid}, 32'd0);
    chk("axi_arid", {28'd0, axi_arid}, 32'd0);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arlock", {30'd0, arlock}, 32'd0);
    chk("arcache", {28'd0, arcache}, 32'd0);
    chk("arprot", {29'd0, arprot}, 32'd0);
    inst_sram_req = 1'b0;
    adv();
    resetn = 1'b1;

    // ---- single fetch ----
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
    @(negedge clk); aok_chk(1'b1); ar_chk(1'b0, 32'd0); exp_q.push_back(32'h0280_0C0C);
    adv(); inst_sram_req = 1'b0; inst_sram_addr = 32'h1C00_00F0;
    @(negedge clk); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0000); rdy_chk(1'b1);
    adv();
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0000);
    adv(); arready = 1'b1;
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0000);
    adv(); arready = 1'b0;
    @(negedge clk); ar_chk(1'b0, 32'd0); sample_r(1'b0);
    adv();
    @(negedge clk); rdy_chk(1'b1);
    adv(); beat(4'd0, 32'h0280_0C0C);
    @(negedge clk); sample_r(1'b1);
    adv(); no_beat();
    @(negedge clk); rdy_chk(1'b0); sample_r(1'b0);
    adv();

    // ---- outstanding limit, return re-enables accept in the same cycle ----
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000;
    @(negedge clk); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0000));
    adv(); inst_sram_addr = 32'h1C00_0004;
    @(negedge clk); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0000);
    adv();
    @(negedge clk); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0004));
    adv(); inst_sram_addr = 32'h1C00_0008;
    @(negedge clk); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0004);
    adv();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); aok_chk(1'b0); ar_chk(1'b0, 32'd0); rdy_chk(1'b1);
      adv();
    end
    beat(4'd0, mem(32'h1C00_0000));
    @(negedge clk); sample_r(1'b1); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0008));
    adv(); inst_sram_req = 1'b0; beat(4'd0, mem(32'h1C00_0004));
    @(negedge clk); sample_r(1'b1); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0008);
    adv(); beat(4'd0, mem(32'h1C00_0008));
    @(negedge clk); sample_r(1'b1); ar_chk(1'b0, 32'd0);
    adv(); no_beat();
    @(negedge clk); rdy_chk(1'b0); sample_r(1'b0);
    adv();

    // ---- simultaneous accept and return at out_cnt=1 ----
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100;
    @(negedge clk); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0100));
    adv(); inst_sram_req = 1'b0;
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0100);
    adv(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0104; beat(4'd0, mem(32'h1C00_0100));
    @(negedge clk); aok_chk(1'b1); sample_r(1'b1); exp_q.push_back(mem(32'h1C00_0104));
    adv(); inst_sram_req = 1'b0; no_beat();
    @(negedge clk); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0104); rdy_chk(1'b1);
    adv(); beat(4'd0, mem(32'h1C00_0104));
    @(negedge clk); sample_r(1'b1); rdy_chk(1'b1);
    adv(); no_beat();
    @(negedge clk); rdy_chk(1'b0);
    adv();

    // ---- AR backpressure while fetch changes the address ----
    arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200;
    @(negedge clk); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0200));
    adv();
    for (int i = 0; i < 5; i++) begin
      inst_sram_addr = 32'h1C00_0300 + 32'(4 * i);
      @(negedge clk); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0200);
      adv();
    end
    arready = 1'b1; inst_sram_addr = 32'h1C00_0204;
    @(negedge clk); aok_chk(1'b0); ar_chk(1'b1, 32'h1C00_0200);
    adv();
    @(negedge clk); aok_chk(1'b1); ar_chk(1'b0, 32'd0); exp_q.push_back(mem(32'h1C00_0204));
    adv(); inst_sram_req = 1'b0;
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0204);
    adv(); arready = 1'b0; beat(4'd0, mem(32'h1C00_0200));
    @(negedge clk); sample_r(1'b1);
    adv(); beat(4'd0, mem(32'h1C00_0204));
    @(negedge clk); sample_r(1'b1);
    adv(); no_beat();
    @(negedge clk); rdy_chk(1'b0);
    adv();

    // ---- foreign ID, beat with nothing outstanding, write request ----
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0400;
    @(negedge clk); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0400));
    adv(); inst_sram_req = 1'b0;
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0400);
    adv(); beat(4'd1, 32'hDEAD_BEEF);
    @(negedge clk); sample_r(1'b0); rdy_chk(1'b1);
    adv(); no_beat();
    @(negedge clk); rdy_chk(1'b1);
    adv(); beat(4'd0, mem(32'h1C00_0400));
    @(negedge clk); sample_r(1'b1);
    adv(); beat(4'd0, 32'hCAFE_F00D);
    @(negedge clk); rdy_chk(1'b0); sample_r(1'b0);
    adv(); no_beat();
    inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1C00_0500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); aok_chk(1'b0); ar_chk(1'b0, 32'd0);
      adv();
    end
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
    @(negedge clk); ar_chk(1'b0, 32'd0);
    adv();

    // ---- asynchronous reset in AR_SEND ----
    arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0600;
    @(negedge clk); aok_chk(1'b1);
    adv(); inst_sram_addr = 32'h1C00_0700;
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0600); rdy_chk(1'b1);
    adv();
    #1 resetn = 1'b0;
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    @(negedge clk); chk("rst_araddr", araddr, 32'd0);
    adv(); resetn = 1'b1;
    @(negedge clk); aok_chk(1'b1); exp_q.push_back(mem(32'h1C00_0700));
    adv(); inst_sram_req = 1'b0; arready = 1'b1;
    @(negedge clk); ar_chk(1'b1, 32'h1C00_0700);
    adv(); arready = 1'b0; beat(4'd0, mem(32'h1C00_0700));
    @(negedge clk); sample_r(1'b1);
    adv(); no_beat();
    @(negedge clk); rdy_chk(1'b0);

    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
